// File: rtl/can_noc_pkg.sv
// Framing constants and types shared by the flit-to-CAN segmenter and the CAN-to-flit reassembler.
// Each CAN frame carries one 64-bit flit segment; the CAN identifier holds {tag, segment index}.
package can_noc_pkg;
  localparam int CAN_ID_W      = 11;
  localparam int TAG_MSB       = 10;
  localparam int TAG_LSB       = 3;
  localparam int SEG_IDX_W     = 3;
  localparam int CAN_PAYLOAD_W = 64;
  localparam int TAG_W         = TAG_MSB - TAG_LSB + 1;

  typedef enum logic [1:0] {IDLE, ASSEMBLE, OUT} state_t;

  typedef struct packed {
    logic [CAN_ID_W-1:0]      id;
    logic [3:0]               dlc;
    logic [CAN_PAYLOAD_W-1:0] data;
  } can_frame_t;

  function automatic int num_seg(input int total_width);
    return (total_width + CAN_PAYLOAD_W - 1) / CAN_PAYLOAD_W;
  endfunction

  // Bytes actually needed in the final frame.
  function automatic int last_dlc(input int total_width);
    return (total_width - CAN_PAYLOAD_W * (num_seg(total_width) - 1) + 7) / 8;
  endfunction
endpackage

// File: rtl/can_seg_check.sv
// Checks one RX frame against the segment expected next: index, tag, DLC and last-segment flag.
// Purely combinational, zero latency; no flow control of its own.
module can_seg_check
  import can_noc_pkg::*;
#(
  parameter int NUM_SEG  = 3,
  parameter int LAST_DLC = 1
) (
  input  logic [CAN_ID_W-1:0]  rx_id,
  input  logic [3:0]           rx_dlc,
  input  logic [SEG_IDX_W-1:0] seg_cnt,
  input  logic [TAG_W-1:0]     tag,
  output logic                 idx_ok,
  output logic                 tag_ok,
  output logic                 dlc_ok,
  output logic                 is_last
);
  logic [SEG_IDX_W-1:0] idx;

  assign idx     = rx_id[SEG_IDX_W-1:0];
  assign idx_ok  = (idx == seg_cnt);
  assign tag_ok  = (rx_id[TAG_MSB:TAG_LSB] == tag);
  assign is_last = (idx == SEG_IDX_W'(NUM_SEG - 1));
  // Required DLC follows the frame's own index, so a restarting index-0 frame is judged correctly.
  assign dlc_ok  = is_last ? (rx_dlc == 4'(LAST_DLC)) : (rx_dlc == 4'd8);
endmodule

// File: rtl/can_flit_reassembler.sv
// Rebuilds a NoC flit from consecutive CAN RX frames; malformed partial flits are dropped and counted.
// o_valid rises the cycle after the last segment is accepted; rx_ready is low while the flit waits for i_ready.
// CAN_REASM_TIMEOUT_EN adds a partial-flit idle timeout of TIMEOUT_CYCLES.
module can_flit_reassembler
  import can_noc_pkg::*;
#(
  parameter int DATA_WIDTH     = 129,
  parameter int X_SIZE         = 1,
  parameter int Y_SIZE         = 1,
  parameter int TOTAL_WIDTH    = X_SIZE + Y_SIZE + DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [CAN_ID_W-1:0]      rx_id,
  input  logic [3:0]               rx_dlc,
  input  logic [CAN_PAYLOAD_W-1:0] rx_data,
  output logic                     rx_ready,
  output logic                     o_valid,
  output logic [TOTAL_WIDTH-1:0]   o_data,
  input  logic                     i_ready,
  output logic                     err,
  output logic [7:0]               drop_cnt
);
  localparam int NUM_SEG  = num_seg(TOTAL_WIDTH);
  localparam int LAST_DLC = last_dlc(TOTAL_WIDTH);

  if (NUM_SEG > (1 << SEG_IDX_W) || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_cfg
    $error("can_flit_reassembler: flit needs more than 8 segments or TIMEOUT_CYCLES out of range");
  end

  state_t                 state_q, state_nxt;
  can_frame_t             rx_frm;
  logic [SEG_IDX_W-1:0]   seg_cnt_q, seg_cnt_nxt, rx_idx;
  logic [TAG_W-1:0]       tag_q;
  logic [TOTAL_WIDTH-1:0] flit_q, seg_mask, seg_rep;
  logic                   accept, start_ok, wr_seg, wr_tag, drop, idle_to;
  logic                   idx_ok, tag_ok, dlc_ok, is_last;

  assign rx_frm   = '{id: rx_id, dlc: rx_dlc, data: rx_data};
  assign rx_idx   = rx_frm.id[SEG_IDX_W-1:0];
  assign rx_ready = !rst && (state_q != OUT);
  assign accept   = rx_valid && rx_ready;
  assign start_ok = (rx_idx == '0) && dlc_ok;
  assign o_valid  = (state_q == OUT);
  assign o_data   = flit_q;

  can_seg_check #(
    .NUM_SEG  (NUM_SEG),
    .LAST_DLC (LAST_DLC)
  ) u_seg_check (
    .rx_id   (rx_frm.id),
    .rx_dlc  (rx_frm.dlc),
    .seg_cnt (seg_cnt_q),
    .tag     (tag_q),
    .idx_ok  (idx_ok),
    .tag_ok  (tag_ok),
    .dlc_ok  (dlc_ok),
    .is_last (is_last)
  );

`ifdef CAN_REASM_TIMEOUT_EN
  logic [15:0] idle_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ASSEMBLE || accept) idle_cnt_q <= '0;
    else                                      idle_cnt_q <= idle_cnt_q + 16'd1;
  end

  // A frame accepted in the expiry cycle takes priority over the timeout.
  assign idle_to = (state_q == ASSEMBLE) && !accept && (idle_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign idle_to = 1'b0;
`endif

  always_comb begin
    state_nxt   = state_q;
    seg_cnt_nxt = seg_cnt_q;
    wr_seg      = 1'b0;
    wr_tag      = 1'b0;
    drop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (start_ok) begin
            wr_seg      = 1'b1;
            wr_tag      = 1'b1;
            seg_cnt_nxt = SEG_IDX_W'(1);
            state_nxt   = (NUM_SEG == 1) ? OUT : ASSEMBLE;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ASSEMBLE: begin
        if (accept) begin
          if (idx_ok && tag_ok && dlc_ok) begin
            wr_seg      = 1'b1;
            seg_cnt_nxt = seg_cnt_q + 1'b1;
            if (is_last) state_nxt = OUT;
          end else if (start_ok) begin
            // A fresh index-0 frame abandons the partial flit and starts a new one.
            drop        = 1'b1;
            wr_seg      = 1'b1;
            wr_tag      = 1'b1;
            seg_cnt_nxt = SEG_IDX_W'(1);
          end else begin
            drop        = 1'b1;
            seg_cnt_nxt = '0;
            state_nxt   = IDLE;
          end
        end else if (idle_to) begin
          drop        = 1'b1;
          seg_cnt_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      OUT: begin
        if (i_ready) begin
          seg_cnt_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload replicated across every 64-bit slot; the mask selects the slot of this frame's index.
  always_comb begin
    seg_mask = '0;
    seg_rep  = '0;
    for (int b = 0; b < TOTAL_WIDTH; b++) begin
      seg_mask[b] = ((b / CAN_PAYLOAD_W) == int'(rx_idx));
      seg_rep[b]  = rx_frm.data[b % CAN_PAYLOAD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      seg_cnt_q <= '0;
      tag_q     <= '0;
      flit_q    <= '0;
      err       <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state_q   <= state_nxt;
      seg_cnt_q <= seg_cnt_nxt;
      err       <= drop;
      if (wr_tag) tag_q <= rx_frm.id[TAG_MSB:TAG_LSB];
      if (wr_seg) flit_q <= (flit_q & ~seg_mask) | (seg_rep & seg_mask);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule
